// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the shared-UART arbiter.
// The arbiter sits on the slave side; requesters plus transmitter sit on the master side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_done;
    logic                          busy;
    logic                          timeout_err;

    modport master (
        output req, req_data, req_last, tx_done,
        input  ack, grant, tx_start, tx_data, busy, timeout_err
    );

    modport slave (
        input  req, req_data, req_last, tx_done,
        output ack, grant, tx_start, tx_data, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// A granted requester keeps the line for a whole message (until a byte with last=1),
// unless it stays silent for HOLD_TIMEOUT cycles between bytes.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned HOLD_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_owner;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    r_ack;
    logic                  r_tx_start;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_hold_cnt;

    state_t                w_state_nx;
    logic [PTR_W-1:0]      w_ptr_nx;
    logic [PTR_W-1:0]      w_owner_nx;
    logic [NUM_REQ-1:0]    w_grant_nx;
    logic [NUM_REQ-1:0]    w_ack_nx;
    logic                  w_tx_start_nx;
    logic [DATA_WIDTH-1:0] w_tx_data_nx;
    logic                  w_last_nx;
    logic                  w_busy_nx;
    logic                  w_timeout_nx;
    logic [CNT_W-1:0]      w_hold_cnt_nx;

    logic [DATA_WIDTH-1:0] w_bytes [NUM_REQ];
    logic                  w_found;
    logic [PTR_W-1:0]      w_sel;
    logic [PTR_W-1:0]      w_owner_inc;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_bytes[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first set req bit at or after ptr, wrapping.
    always_comb begin : sel_search
        int unsigned idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(r_ptr) + i) % NUM_REQ;
            if (!w_found && bus.req[PTR_W'(idx)]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'(idx);
            end
        end
    end

    // Pointer value after releasing the current owner.
    assign w_owner_inc = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

    // Next-state and next-output logic; ack/tx_start are set on entry to START.
    always_comb begin
        w_state_nx    = r_state;
        w_ptr_nx      = r_ptr;
        w_owner_nx    = r_owner;
        w_grant_nx    = r_grant;
        w_ack_nx      = '0;
        w_tx_start_nx = 1'b0;
        w_tx_data_nx  = r_tx_data;
        w_last_nx     = r_last;
        w_timeout_nx  = 1'b0;
        w_hold_cnt_nx = r_hold_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nx    = S_START;
                    w_owner_nx    = w_sel;
                    w_grant_nx    = onehot(w_sel);
                    w_ack_nx      = onehot(w_sel);
                    w_tx_start_nx = 1'b1;
                    w_tx_data_nx  = w_bytes[w_sel];
                    w_last_nx     = bus.req_last[w_sel];
                end
            end
            S_START: begin
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    if (r_last) begin
                        w_state_nx = S_IDLE;
                        w_grant_nx = '0;
                        w_ptr_nx   = w_owner_inc;
                    end else begin
                        w_state_nx    = S_HOLD;
                        w_hold_cnt_nx = '0;
                    end
                end
            end
            S_HOLD: begin
                if (bus.req[r_owner]) begin
                    w_state_nx    = S_START;
                    w_ack_nx      = onehot(r_owner);
                    w_tx_start_nx = 1'b1;
                    w_tx_data_nx  = w_bytes[r_owner];
                    w_last_nx     = bus.req_last[r_owner];
                end else if (r_hold_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
                    w_state_nx    = S_IDLE;
                    w_grant_nx    = '0;
                    w_ptr_nx      = w_owner_inc;
                    w_timeout_nx  = 1'b1;
                    w_hold_cnt_nx = '0;
                end else begin
                    w_hold_cnt_nx = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // State and output registers; reset drops any lock immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_owner    <= w_owner_nx;
            r_grant    <= w_grant_nx;
            r_ack      <= w_ack_nx;
            r_tx_start <= w_tx_start_nx;
            r_tx_data  <= w_tx_data_nx;
            r_last     <= w_last_nx;
            r_busy     <= w_busy_nx;
            r_timeout  <= w_timeout_nx;
            r_hold_cnt <= w_hold_cnt_nx;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.grant       = r_grant;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_data     = r_tx_data;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ independent byte producers, e.g. a string sender, a debug dumper and a status reporter.
- Arbitrates round-robin, one byte at a time, and issues the transmitter's start/done handshake.
- Supports multi-byte messages through a `last` flag, so a granted requester keeps the line until its message is complete. Messages from different requesters never interleave.
- Sits between the requesters and the transmitter system (inputs `tx_start`, `data_in`; output `tx_done`).

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: byte width.
- HOLD_TIMEOUT, 16: cycles a granted requester may leave `req` low between bytes of one message before the lock is forcibly released (>= 2).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester byte request; held high with stable data until the matching `ack`.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  requester i: this byte ends its message.
- ack  out  NUM_REQ  one-cycle pulse: byte of requester i captured; requester may change data/req next cycle.
- grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when free.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DATA_WIDTH  byte to the transmitter; stable from the `tx_start` cycle until `tx_done`.
- tx_done  in  1  one-cycle pulse from the transmitter after the stop bit.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when a message lock is released by timeout.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, round-robin pointer `ptr` = 0, `ack` = 0, `grant` = 0, `tx_start` = 0, `tx_data` = 0, `busy` = 0, `timeout_err` = 0, hold counter = 0, `last_q` = 0.
- Reset is asynchronous. If asserted mid-byte or mid-message, the block returns to IDLE immediately and discards the lock. A partial message is not resumed.
- Selection: search `req` starting at index `ptr`, wrapping modulo NUM_REQ. The first set bit wins; its index is `sel`.
- IDLE:
  - If `req` is nonzero at a clock edge, go to START.
  - Register `grant` = onehot(sel), `tx_data` = req_data[sel], `last_q` = req_last[sel].
- START (exactly 1 cycle):
  - `tx_start` = 1 and `ack[sel]` = 1 in this cycle.
  - Then go to WAIT.
  - Latency from `req` sampled in IDLE to `tx_start` is 1 cycle.
- WAIT:
  - Hold `tx_data` and `grant`; ignore all `req`.
  - On `tx_done`:
    - If `last_q` = 1: go to IDLE, clear `grant`, set `ptr` = (owner+1) mod NUM_REQ.
    - If `last_q` = 0: go to HOLD and clear the hold counter.
- HOLD:
  - Only the owner's `req` is examined; other requests wait.
  - If `req[owner]` = 1: capture `req_data[owner]` and `req_last[owner]`, then go to START.
  - Otherwise increment the hold counter. When it reaches HOLD_TIMEOUT-1: pulse `timeout_err`, clear `grant`, set `ptr` = owner+1, go to IDLE.
- `tx_done` outside WAIT is ignored and does not change state.
- `tx_start` is never asserted outside START. At most one `ack` bit is high in any cycle.
- Pointer wrap: owner NUM_REQ-1 gives `ptr` = 0.
- Requests arriving in the same cycle as a release are arbitrated in the following IDLE cycle with the updated `ptr`.
- A requester dropping `req` before `ack` is legal in IDLE (the request is withdrawn).

Test Plan:
- Single request: reset, then `req` = 4'b0100, req_data[2] = 8'h48, `last` = 1 → `tx_start` and `ack` = 4'b0100 one cycle later, `tx_data` = 8'h48. After a 10-cycle model `tx_done`: `grant` = 0, `busy` = 0, `ptr` = 3.
- Round-robin: `req` = 4'b1111 held, every byte `last` = 1, model `tx_done` after 10 cycles → grant order 0,1,2,3,0. `ack` pulses exactly once per byte.
- Message lock: requester 1 sends "Hi\r\n" (8'h48, 8'h69, 8'h0D, 8'h0A; `last` only on 8'h0A) while requester 3 requests continuously → four requester-1 bytes go out contiguously, then requester 3 is granted.
- Hold timeout: requester 0 sends 8'h41 with `last` = 0, then drops `req` → after HOLD_TIMEOUT = 16 cycles in HOLD, `timeout_err` pulses, `grant` = 0, `ptr` = 1.
- Reset mid-operation: assert reset during WAIT of a locked message → all outputs go to reset values asynchronously. After release with `req` = 4'b0001, requester 0 is granted as a fresh message.
- Spurious `tx_done` in IDLE and HOLD, and `req` withdrawn before `ack` → no state change, no `tx_start`, no `ack`.
